// File: rtl/tt_dco.sv
// tt_dco: DCO stage turning a loop-filter control word into a clamped FCW,
// a wrapping phase accumulator clock and a divided feedback clock.
module tt_dco #(
  parameter int               ACC_W      = 24,
  parameter logic [ACC_W-1:0] CENTER_FCW = 24'h100000,
  parameter logic [ACC_W-1:0] FCW_MIN    = 24'h010000,
  parameter logic [ACC_W-1:0] FCW_MAX    = 24'h400000,
  parameter int               CTRL_SHIFT = 4,
  parameter int               DIV_N      = 8
) (
  input  logic               i_clk_gen,
  input  logic               i_rst,
  input  logic signed [31:0] i_ctrl,
  output logic               o_dco_clk,
  output logic               o_fb_clk,
  output logic [ACC_W-1:0]   o_fcw,
  output logic               o_sat_hi,
  output logic               o_sat_lo,
  input  logic               i_scan_en,
  input  logic               i_scan_in,
  output logic               o_scan_out
);
  localparam int DW = DIV_N > 1 ? $clog2(DIV_N) : 1;
  logic signed [31:0] ctrl_q, ctrl_d, ctrl_sh;
  logic signed [33:0] sum;
  logic [ACC_W-1:0]   fcw_q, fcw_d, acc_q, acc_d;
  logic               sat_hi_q, sat_hi_d, sat_lo_q, sat_lo_d;
  logic               msb_prev_q, msb_prev_d, fb_q, fb_d, rise, hi, lo;
  logic [DW-1:0]      div_cnt_q, div_cnt_d;
  // 34-bit signed sum: zero-extended centre plus sign-extended offset cannot overflow
  always_comb begin
    ctrl_sh    = ctrl_q >>> CTRL_SHIFT;
    sum        = $signed(34'(CENTER_FCW)) + 34'(ctrl_sh);
    hi         = sum > $signed(34'(FCW_MAX));
    lo         = sum < $signed(34'(FCW_MIN));
    ctrl_d     = i_scan_en ? ctrl_q : i_ctrl;
    fcw_d      = i_scan_en ? fcw_q : hi ? FCW_MAX : lo ? FCW_MIN : sum[ACC_W-1:0];
    sat_hi_d   = i_scan_en ? sat_hi_q : hi;
    sat_lo_d   = i_scan_en ? sat_lo_q : lo;
    acc_d      = i_scan_en ? {acc_q[ACC_W-2:0], i_scan_in} : acc_q + fcw_q;
    msb_prev_d = i_scan_en ? msb_prev_q : acc_q[ACC_W-1];
    rise       = !i_scan_en && acc_q[ACC_W-1] && !msb_prev_q;
    div_cnt_d  = !rise ? div_cnt_q : div_cnt_q == DW'(DIV_N - 1) ? '0 : div_cnt_q + 1'b1;
    fb_d       = rise && div_cnt_q == DW'(DIV_N - 1) ? !fb_q : fb_q;
  end
  always_ff @(posedge i_clk_gen or posedge i_rst) begin
    if (i_rst) begin
      ctrl_q     <= '0;
      fcw_q      <= CENTER_FCW;
      sat_hi_q   <= 1'b0;
      sat_lo_q   <= 1'b0;
      acc_q      <= '0;
      msb_prev_q <= 1'b0;
      div_cnt_q  <= '0;
      fb_q       <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      fcw_q      <= fcw_d;
      sat_hi_q   <= sat_hi_d;
      sat_lo_q   <= sat_lo_d;
      acc_q      <= acc_d;
      msb_prev_q <= msb_prev_d;
      div_cnt_q  <= div_cnt_d;
      fb_q       <= fb_d;
    end
  end
  assign o_dco_clk  = acc_q[ACC_W-1];
  assign o_scan_out = acc_q[ACC_W-1];
  assign o_fb_clk   = fb_q;
  assign o_fcw      = fcw_q;
  assign o_sat_hi   = sat_hi_q;
  assign o_sat_lo   = sat_lo_q;
endmodule

// File: tb/tb_tt_dco.sv
// tb_tt_dco: directed checks of tt_dco pipeline, clamping, divider, scan and async reset.
module tb_tt_dco;
  logic        clk = 1'b0, rst = 1'b0, scan_en = 1'b0, scan_in = 1'b0;
  logic [31:0] ctrl = '0;
  logic        dco, fb, sat_hi, sat_lo, scan_out;
  logic [23:0] fcw, d;
  int          errors = 0, checks = 0;
  logic [31:0] vc [9] = '{32'h00100000, 32'hFFFFFFFF, 32'h03000000, 32'h03000010,
                          32'hFF100000, 32'hFF0FFFF0, 32'h80000000, 32'h7FFFFFFF, 32'h0000000F};
  logic [23:0] vf [9] = '{24'h110000, 24'h0FFFFF, 24'h400000, 24'h400000,
                          24'h010000, 24'h010000, 24'h010000, 24'h400000, 24'h100000};
  logic [8:0]  vh = 9'b010001000;
  logic [8:0]  vl = 9'b001100000;

  always #5 clk = ~clk;

  tt_dco dut (
    .i_clk_gen(clk), .i_rst(rst), .i_ctrl(ctrl), .o_dco_clk(dco), .o_fb_clk(fb),
    .o_fcw(fcw), .o_sat_hi(sat_hi), .o_sat_lo(sat_lo),
    .i_scan_en(scan_en), .i_scan_in(scan_in), .o_scan_out(scan_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input logic [31:0] c);
    rst = 1'b1;
    scan_en = 1'b0;
    ctrl = c;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic scan(input logic [23:0] din, output logic [23:0] dout);
    for (int i = 23; i >= 0; i--) begin
      scan_en = 1'b1;
      scan_in = din[i];
      dout[i] = scan_out;
      tick(1);
    end
    scan_en = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst fcw", 32'(fcw), 32'h100000);
    chk("rst dco", 32'(dco), 0);
    chk("rst fb", 32'(fb), 0);
    chk("rst hi", 32'(sat_hi), 0);
    chk("rst lo", 32'(sat_lo), 0);
    tick(2);
    rst = 1'b0;
    for (int k = 1; k <= 392; k++) begin
      tick(1);
      if (k == 7 || k == 16) chk("free dco low", 32'(dco), 0);
      if (k == 8 || k == 15) chk("free dco high", 32'(dco), 1);
      if (k == 120 || k == 249) chk("free fb low", 32'(fb), 0);
      if (k == 121 || k == 248) chk("free fb high", 32'(fb), 1);
      if (k == 100) chk("free fcw", 32'(fcw), 32'h100000);
    end
    chk("pre-rst dco", 32'(dco), 1);
    chk("pre-rst fb", 32'(fb), 1);
    #2 rst = 1'b1;
    #1;
    chk("async dco", 32'(dco), 0);
    chk("async fb", 32'(fb), 0);
    chk("async fcw", 32'(fcw), 32'h100000);
    tick(1);
    rst = 1'b0;
    tick(7);
    chk("post-rst dco 7", 32'(dco), 0);
    tick(1);
    chk("post-rst dco 8", 32'(dco), 1);

    start(32'h00100000);
    tick(1);
    chk("step fcw n", 32'(fcw), 32'h100000);
    tick(1);
    chk("step fcw n+1", 32'(fcw), 32'h110000);
    tick(1);
    scan(24'hA5A5A5, d);
    chk("step acc", 32'(d), 32'h310000);
    chk("scan fcw hold", 32'(fcw), 32'h110000);
    chk("scan fb hold", 32'(fb), 0);
    tick(1);
    scan(24'h000000, d);
    chk("scan resume acc", 32'(d), 32'hB6A5A5);

    start(32'h7FFFFFFF);
    tick(2);
    chk("sat hi fcw", 32'(fcw), 32'h400000);
    chk("sat hi flag", 32'(sat_hi), 1);
    chk("sat hi lo flag", 32'(sat_lo), 0);
    tick(4);
    chk("sat dco 6", 32'(dco), 0);
    tick(1);
    chk("sat dco 7", 32'(dco), 0);
    tick(1);
    chk("sat dco 8", 32'(dco), 1);
    tick(1);
    chk("sat dco 9", 32'(dco), 1);
    ctrl = '0;
    tick(1);
    chk("sat hi hold", 32'(sat_hi), 1);
    tick(1);
    chk("sat hi clear", 32'(sat_hi), 0);
    chk("sat clear fcw", 32'(fcw), 32'h100000);
    for (int i = 0; i < 9; i++) begin
      ctrl = vc[i];
      tick(2);
      chk($sformatf("vec%0d fcw", i), 32'(fcw), 32'(vf[i]));
      chk($sformatf("vec%0d hi", i), 32'(sat_hi), 32'(vh[i]));
      chk($sformatf("vec%0d lo", i), 32'(sat_lo), 32'(vl[i]));
    end

    start(32'h80000000);
    for (int k = 1; k <= 3939; k++) begin
      tick(1);
      if (k == 2) chk("sat lo fcw", 32'(fcw), 32'h010000);
      if (k == 2) chk("sat lo flag", 32'(sat_lo), 1);
      if (k == 97 || k == 226 || k == 353) chk("slow dco low", 32'(dco), 0);
      if (k == 98 || k == 225 || k == 354) chk("slow dco high", 32'(dco), 1);
      if (k == 1890 || k == 3939) chk("slow fb low", 32'(fb), 0);
      if (k == 1891 || k == 3938) chk("slow fb high", 32'(fb), 1);
    end

    start(32'h0);
    tick(1);
    scan(24'hA5A5A5, d);
    chk("scan out prior", 32'(d), 32'h100000);
    scan(24'h100000, d);
    chk("scan out shifted", 32'(d), 32'hA5A5A5);
    for (int k = 50; k <= 169; k++) begin
      tick(1);
      if (k == 168) chk("scan no div fb low", 32'(fb), 0);
      if (k == 169) chk("scan no div fb high", 32'(fb), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tt_dco.md
Name: tt_dco

Overview:
Digitally controlled oscillator stage that consumes the loop filter's signed 32-bit control word and produces the synthesized clock. A frequency control word (FCW) is formed as a centre value plus a scaled, saturated control offset. The FCW drives a wrapping phase accumulator whose MSB is the DCO output. A feedback divider returns a divided clock to the phase detector, closing the loop.

Parameters:
ACC_W, 24, phase accumulator and FCW width in bits
CENTER_FCW, 24'h100000, free-running FCW when the control word is 0
FCW_MIN, 24'h010000, lower FCW clamp; legal range 1 <= FCW_MIN
FCW_MAX, 24'h400000, upper FCW clamp; legal range FCW_MAX <= 2^(ACC_W-1), FCW_MIN <= CENTER_FCW <= FCW_MAX
CTRL_SHIFT, 4, arithmetic right shift applied to the control word before the add
DIV_N, 8, feedback divider ratio in DCO rising edges per o_fb_clk half-period; DIV_N >= 1

Ports:
i_clk_gen  in  1  system clock; all state on its rising edge
i_rst  in  1  asynchronous, active-high reset
i_ctrl  in  32  signed control word from the loop filter
o_dco_clk  out  1  DCO output, equal to the accumulator MSB
o_fb_clk  out  1  divided feedback clock to the phase detector
o_fcw  out  ACC_W  currently applied FCW, registered
o_sat_hi  out  1  FCW clamped to FCW_MAX this cycle
o_sat_lo  out  1  FCW clamped to FCW_MIN this cycle
i_scan_en  in  1  scan shift enable
i_scan_in  in  1  scan data in
o_scan_out  out  1  scan data out

Behaviour:
- Reset (asynchronous, active-high):
  - ctrl_q=0, fcw_q=CENTER_FCW, acc=0, msb_prev=0, div_cnt=0.
  - Outputs: o_fb_clk=0, o_sat_hi=0, o_sat_lo=0, o_dco_clk=0, o_fcw=CENTER_FCW.
  - All outputs take reset values immediately on i_rst assertion, without waiting for a clock edge.
- Pipeline, clock edge n:
  - ctrl_q <= i_ctrl.
  - Edge n+1: fcw_q <= sat(CENTER_FCW + (ctrl_q >>> CTRL_SHIFT)).
  - Edge n+2: the first accumulator increment uses the new fcw_q.
  - Control-to-increment latency is therefore 2 cycles.
- Arithmetic:
  - Shift is arithmetic (sign-preserving).
  - The sum is formed at 34-bit signed width with CENTER_FCW zero-extended, so overflow is impossible.
  - If sum > FCW_MAX: fcw_q = FCW_MAX and o_sat_hi = 1.
  - If sum < FCW_MIN: fcw_q = FCW_MIN and o_sat_lo = 1.
  - Otherwise fcw_q = sum[ACC_W-1:0] and both flags are 0.
  - The flags register together with fcw_q, and are never both 1.
- Accumulator:
  - acc <= acc + fcw_q every cycle, wrapping modulo 2^ACC_W.
  - o_dco_clk = acc[ACC_W-1] (registered bit).
  - DCO period = 2^ACC_W / fcw_q clocks. Fractional periods appear as jitter between floor and ceiling.
- Feedback divider:
  - msb_prev <= acc MSB each cycle; a rising edge is detected when MSB=1 and msb_prev=0.
  - On each rising edge: if div_cnt == DIV_N-1, then div_cnt <= 0 and o_fb_clk toggles; otherwise div_cnt increments.
  - o_fb_clk period = 2*DIV_N DCO periods.
  - DIV_N = 1: o_fb_clk toggles on every DCO rising edge.
- Scan (i_scan_en=1, takes priority over normal update):
  - The chain covers acc only: acc[0] <= i_scan_in, acc[i] <= acc[i-1].
  - o_scan_out = acc[ACC_W-1].
  - ctrl_q, fcw_q, the flags, div_cnt, msb_prev and o_fb_clk hold.
  - Scan shifting is not a rising-edge source: msb_prev holds, no divider events occur.
  - When i_scan_en drops, accumulation resumes from the shifted-in value on the next edge.
- Reset mid-scan or mid-operation overrides everything; the first post-reset increment uses CENTER_FCW.

Test Plan:
- Free-run, defaults, i_ctrl=0 after reset: o_fcw=0x100000; o_dco_clk is 0 for 8 clocks, 1 for 8 clocks (period 16); o_fb_clk period 256 clocks; flags 0.
- Step, i_ctrl 0 -> 0x00100000 at edge n: o_fcw=0x110000 after edge n+1; the accumulator delta changes from 0x100000 to 0x110000 starting at edge n+2.
- Saturation high, i_ctrl=0x7FFFFFFF: o_fcw=0x400000, o_sat_hi=1, o_sat_lo=0; o_dco_clk period 4 clocks. Returning to i_ctrl=0 clears o_sat_hi 2 cycles later.
- Saturation low, i_ctrl=0x80000000: o_fcw=0x010000, o_sat_lo=1; o_dco_clk period 256 clocks; o_fb_clk period 4096 clocks.
- Scan, 24 cycles with i_scan_en=1 shifting 0xA5A5A5 MSB-first:
  - o_scan_out emits the prior acc bits MSB-first.
  - After the shift, acc=0xA5A5A5; o_fcw, div_cnt and o_fb_clk are unchanged.
  - The next normal edge gives acc=0xA5A5A5+fcw_q.
- Async reset mid-run, i_rst asserted between edges while o_dco_clk=1 and o_fb_clk=1: both drop to 0 immediately and o_fcw=0x100000. After release, the first o_dco_clk rise occurs after 8 edges.
